// File: rtl/au_seq.sv
`default_nettype none
// ============================================================================
// Module   : au_seq
// Purpose  : Two-cycle microsequencer driving the 8-bit arithmetic unit from a
//            16-entry ROM, with a 4 x 8 register file and latched greater flag.
//            Optional JGF conditional jump is built when AU_SEQ_JGF_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module au_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] ir,
    output logic [3:0] pc,
    output logic       au_en,
    output logic [3:0] ac,
    output logic [7:0] a,
    output logic [7:0] b,
    input  logic [7:0] t,
    input  logic       gf,
    output logic       busy,
    output logic       done,
    output logic [7:0] r0
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_EXEC  = 2'd2;
    localparam logic [1:0] c_ST_HALT  = 2'd3;

    localparam logic [3:0] c_OP_ADD  = 4'b1000;
    localparam logic [3:0] c_OP_SUB  = 4'b1001;
    localparam logic [3:0] c_OP_MOV  = 4'b0100;
    localparam logic [3:0] c_OP_LDI  = 4'b0001;
    localparam logic [3:0] c_OP_HALT = 4'b1111;
`ifdef AU_SEQ_JGF_EN
    localparam logic [3:0] c_OP_JGF  = 4'b0010;
`endif

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [3:0] r_pc;
    logic [3:0] w_pc_nxt;
    logic [7:0] r_ir;
    logic [7:0] r_rf [4];
    logic       r_gf;

    logic       w_ir_ld;
    logic       w_wr_en;
    logic [7:0] w_wr_data;
    logic       w_gf_ld;

    logic [3:0] w_op;
    logic [1:0] w_rd;
    logic [1:0] w_rb;

    assign w_op = r_ir[7:4];
    assign w_rd = r_ir[3:2];
    assign w_rb = r_ir[1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_ld     = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_data   = 8'h00;
        w_gf_ld     = 1'b0;
        au_en       = 1'b0;
        ac          = 4'b0000;
        a           = 8'h00;
        b           = 8'h00;

        case (r_state)
            c_ST_IDLE, c_ST_HALT: begin
                if (start) begin
                    w_state_nxt = c_ST_FETCH;
                    w_pc_nxt    = 4'd0;
                end
            end
            c_ST_FETCH: begin
                w_ir_ld     = 1'b1;
                w_pc_nxt    = r_pc + 4'd1;
                w_state_nxt = c_ST_EXEC;
            end
            c_ST_EXEC: begin
                w_state_nxt = c_ST_FETCH;
                case (w_op)
                    c_OP_ADD: begin
                        au_en     = 1'b1;
                        ac        = c_OP_ADD;
                        a         = r_rf[w_rd];
                        b         = r_rf[w_rb];
                        w_wr_en   = 1'b1;
                        w_wr_data = t;
                    end
                    // Operands swap for SUB so the AU's b-a yields rd-rb
                    c_OP_SUB: begin
                        au_en     = 1'b1;
                        ac        = c_OP_SUB;
                        a         = r_rf[w_rb];
                        b         = r_rf[w_rd];
                        w_wr_en   = 1'b1;
                        w_wr_data = t;
                        w_gf_ld   = 1'b1;
                    end
                    c_OP_MOV: begin
                        au_en     = 1'b1;
                        ac        = c_OP_MOV;
                        a         = r_rf[w_rb];
                        w_wr_en   = 1'b1;
                        w_wr_data = t;
                    end
                    // ROM already presents the byte after the opcode
                    c_OP_LDI: begin
                        w_wr_en   = 1'b1;
                        w_wr_data = ir;
                        w_pc_nxt  = r_pc + 4'd1;
                    end
`ifdef AU_SEQ_JGF_EN
                    c_OP_JGF: begin
                        if (r_gf) begin
                            w_pc_nxt = r_ir[3:0];
                        end
                    end
`endif
                    c_OP_HALT: begin
                        w_state_nxt = c_ST_HALT;
                    end
                    default: begin
                    end
                endcase
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_pc    <= 4'd0;
            r_ir    <= 8'h00;
            r_gf    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_rf[i] <= 8'h00;
            end
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_ir_ld) begin
                r_ir <= ir;
            end
            if (w_wr_en) begin
                r_rf[w_rd] <= w_wr_data;
            end
            if (w_gf_ld) begin
                r_gf <= gf;
            end
        end
    end

    assign pc   = r_pc;
    assign busy = (r_state == c_ST_FETCH) || (r_state == c_ST_EXEC);
    assign done = (r_state == c_ST_HALT);
    assign r0   = r_rf[0];

endmodule
`default_nettype wire

// File: tb/tb_au_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_au_seq
// Purpose  : Self-checking bench for au_seq: vector table, directed corner
//            sequences and random programs against an instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_au_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] ir;
    logic [3:0] pc;
    logic       au_en;
    logic [3:0] ac;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] t;
    logic       gf;
    logic       busy;
    logic       done;
    logic [7:0] r0;

    logic [7:0] rom [16];
    logic [7:0] noise;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign ir = rom[pc];

    // Combinational AU; garbage on non-AU codes exposes stray write-backs
    always_comb begin
        case (ac)
            4'b1000: t = a + b;
            4'b1001: t = b - a;
            4'b0100: t = a;
            default: t = noise;
        endcase
    end
    assign gf = $signed(b) > $signed(a);

    always @(posedge clk) noise <= 8'($urandom);

    au_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .ir    (ir),
        .pc    (pc),
        .au_en (au_en),
        .ac    (ac),
        .a     (a),
        .b     (b),
        .t     (t),
        .gf    (gf),
        .busy  (busy),
        .done  (done),
        .r0    (r0)
    );

    typedef struct packed {
        logic [7:0] instr;
        logic [7:0] v1;
        logic [7:0] v2;
        logic       en;
        logic [3:0] eac;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       cb;
        logic [7:0] res;
    } vec_t;

    vec_t vt [10];

    logic [7:0] m_r [4];
    logic       m_gf;
    logic [3:0] m_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst   = 1'b1;
        start = 1'b0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic clear_rom;
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_au_en"}, 32'(au_en), 32'h0);
        chk({tag, "_ac"}, 32'(ac), 32'h0);
        chk({tag, "_a"}, 32'(a), 32'h0);
        chk({tag, "_b"}, 32'(b), 32'h0);
    endtask

    function automatic logic [7:0] gen_byte();
        int unsigned r;
        logic [3:0]  op;
        r = $urandom_range(0, 15);
        if (r < 4)       op = 4'b1000;
        else if (r < 7)  op = 4'b1001;
        else if (r < 9)  op = 4'b0100;
        else if (r < 12) op = 4'b0001;
        else if (r < 13) op = 4'b0010;
        else if (r < 14) op = 4'b1111;
        else             op = 4'($urandom);
        return {op, 4'($urandom)};
    endfunction

    // Instruction-level reference: each instruction is one FETCH + one EXEC
    task automatic run_random(input int nins);
        logic [7:0] ins, imm;
        logic [3:0] op, nxt, e_ac;
        logic [1:0] rd, rb;
        logic       e_en, cb, halted, stop;
        logic [7:0] e_a, e_b;
        for (int i = 0; i < 16; i++) rom[i] = gen_byte();
        do_reset;
        for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
        m_gf = 1'b0;
        stop = 1'b0;
        for (int k = 0; k < 3 && !stop; k++) begin
            pulse_start;
            m_pc   = 4'd0;
            halted = 1'b0;
            for (int n = 0; n < nins && !halted; n++) begin
                chk("rnd_fetch_pc", 32'(pc), 32'(m_pc));
                chk("rnd_fetch_busy", 32'(busy), 32'h1);
                chk("rnd_fetch_au_en", 32'(au_en), 32'h0);
                ins = rom[m_pc];
                imm = rom[m_pc + 4'd1];
                op  = ins[7:4];
                rd  = ins[3:2];
                rb  = ins[1:0];
                e_en = 1'b0; e_ac = 4'h0; e_a = 8'h00; e_b = 8'h00; cb = 1'b1;
                nxt = m_pc + 4'd1;
                start = 1'($urandom);
                tick;
                start = 1'($urandom);
                case (op)
                    4'b1000: begin e_en = 1'b1; e_ac = op; e_a = m_r[rd]; e_b = m_r[rb]; end
                    4'b1001: begin e_en = 1'b1; e_ac = op; e_a = m_r[rb]; e_b = m_r[rd]; end
                    4'b0100: begin e_en = 1'b1; e_ac = op; e_a = m_r[rb]; cb = 1'b0; end
                    default: ;
                endcase
                chk("rnd_exec_au_en", 32'(au_en), 32'(e_en));
                chk("rnd_exec_ac", 32'(ac), 32'(e_ac));
                chk("rnd_exec_a", 32'(a), 32'(e_a));
                if (cb) chk("rnd_exec_b", 32'(b), 32'(e_b));
                case (op)
                    4'b1000: m_r[rd] = 8'((int'(m_r[rd]) + int'(m_r[rb])) % 256);
                    4'b1001: begin
                        m_gf    = $signed(m_r[rd]) > $signed(m_r[rb]);
                        m_r[rd] = 8'((int'(m_r[rd]) - int'(m_r[rb]) + 256) % 256);
                    end
                    4'b0100: m_r[rd] = m_r[rb];
                    4'b0001: begin m_r[rd] = imm; nxt = m_pc + 4'd2; end
`ifdef AU_SEQ_JGF_EN
                    4'b0010: if (m_gf) nxt = ins[3:0];
`endif
                    4'b1111: halted = 1'b1;
                    default: ;
                endcase
                tick;
                start = 1'b0;
                m_pc  = nxt;
                chk("rnd_r0", 32'(r0), 32'(m_r[0]));
                if (halted) begin
                    chk("rnd_halt_done", 32'(done), 32'h1);
                    chk("rnd_halt_busy", 32'(busy), 32'h0);
                end
            end
            if (!halted) stop = 1'b1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_pc;
        rst   = 1'b1;
        start = 1'b0;
        clear_rom;

        //           instr  v1     v2     en    ac    ea     eb     cb    res
        vt[0] = '{8'h86, 8'h05, 8'h03, 1'b1, 4'h8, 8'h05, 8'h03, 1'b1, 8'h08};
        vt[1] = '{8'h96, 8'h08, 8'h03, 1'b1, 4'h9, 8'h03, 8'h08, 1'b1, 8'h05};
        vt[2] = '{8'h96, 8'h01, 8'hFF, 1'b1, 4'h9, 8'hFF, 8'h01, 1'b1, 8'h02};
        vt[3] = '{8'h46, 8'h05, 8'h7A, 1'b1, 4'h4, 8'h7A, 8'h00, 1'b0, 8'h7A};
        vt[4] = '{8'h06, 8'h05, 8'h03, 1'b0, 4'h0, 8'h00, 8'h00, 1'b1, 8'h05};
        vt[5] = '{8'h86, 8'hF0, 8'h20, 1'b1, 4'h8, 8'hF0, 8'h20, 1'b1, 8'h10};
        vt[6] = '{8'h36, 8'h05, 8'h03, 1'b0, 4'h0, 8'h00, 8'h00, 1'b1, 8'h05};
        vt[7] = '{8'h89, 8'h05, 8'h03, 1'b1, 4'h8, 8'h03, 8'h05, 1'b1, 8'h08};
        vt[8] = '{8'h96, 8'h03, 8'h08, 1'b1, 4'h9, 8'h08, 8'h03, 1'b1, 8'hFB};
        vt[9] = '{8'h99, 8'h10, 8'h80, 1'b1, 4'h9, 8'h10, 8'h80, 1'b1, 8'h70};

        // Reset state
        do_reset;
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_r0", 32'(r0), 32'h0);
        chk_quiet("rst");

        // Vector table: preload R1/R2, run one instruction, copy R[rd] to R0
        for (int i = 0; i < 10; i++) begin
            clear_rom;
            rom[0] = 8'h14; rom[1] = vt[i].v1;
            rom[2] = 8'h18; rom[3] = vt[i].v2;
            rom[4] = vt[i].instr;
            rom[5] = {6'b010000, vt[i].instr[3:2]};
            rom[6] = 8'hF0;
            pulse_start;
            chk_quiet($sformatf("tbl%0d_fetch", i));
            repeat (5) tick;
            chk($sformatf("tbl%0d_au_en", i), 32'(au_en), 32'(vt[i].en));
            chk($sformatf("tbl%0d_ac", i), 32'(ac), 32'(vt[i].eac));
            chk($sformatf("tbl%0d_a", i), 32'(a), 32'(vt[i].ea));
            if (vt[i].cb) chk($sformatf("tbl%0d_b", i), 32'(b), 32'(vt[i].eb));
            repeat (3) tick;
            chk($sformatf("tbl%0d_res", i), 32'(r0), 32'(vt[i].res));
            repeat (2) tick;
            chk($sformatf("tbl%0d_done", i), 32'(done), 32'h1);
        end

        // Arithmetic program, with a start pulse during EXEC that must be ignored
        clear_rom;
        rom[0] = 8'h14; rom[1] = 8'h05; rom[2] = 8'h18; rom[3] = 8'h03;
        rom[4] = 8'h86; rom[5] = 8'h96; rom[6] = 8'h41; rom[7] = 8'hF0;
        pulse_start;
        repeat (5) tick;
        chk("prog_add_a", 32'(a), 32'h05);
        chk("prog_add_b", 32'(b), 32'h03);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("prog_start_ignored_pc", 32'(pc), 32'h5);
        chk("prog_start_ignored_busy", 32'(busy), 32'h1);
        tick;
        chk("prog_sub_a", 32'(a), 32'h03);
        chk("prog_sub_b", 32'(b), 32'h08);
        chk("prog_sub_ac", 32'(ac), 32'h9);
        repeat (2) tick;
        chk("prog_mov_a", 32'(a), 32'h05);
        tick;
        chk("prog_r0", 32'(r0), 32'h05);
        tick;
        chk("prog_done_early", 32'(done), 32'h0);
        tick;
        chk("prog_done_rise", 32'(done), 32'h1);
        chk("prog_busy_halt", 32'(busy), 32'h0);
        chk_quiet("prog_halt");
        repeat (4) tick;
        chk("prog_done_16", 32'(done), 32'h1);

        // Mid-program reset with start asserted on the same edges
        clear_rom;
        rom[0] = 8'h10; rom[1] = 8'h77; rom[2] = 8'h10; rom[3] = 8'h55;
        pulse_start;
        repeat (2) tick;
        chk("mid_r0_loaded", 32'(r0), 32'h77);
        tick;
        rst   = 1'b1;
        start = 1'b1;
        tick;
        tick;
        rst   = 1'b0;
        start = 1'b0;
        chk("mid_rst_pc", 32'(pc), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_done", 32'(done), 32'h0);
        chk("mid_rst_r0", 32'(r0), 32'h0);
        chk_quiet("mid_rst");
        tick;
        chk("mid_idle_busy", 32'(busy), 32'h0);
        pulse_start;
        chk("mid_restart_pc", 32'(pc), 32'h0);
        chk("mid_restart_busy", 32'(busy), 32'h1);

        // pc wrap: LDI at 15 takes its immediate from address 0
        do_reset;
        clear_rom;
        rom[0]  = 8'h0C;
        rom[15] = 8'h10;
        pulse_start;
        repeat (30) tick;
        chk("wrap_fetch_pc", 32'(pc), 32'hF);
        tick;
        chk("wrap_exec_pc", 32'(pc), 32'h0);
        chk_quiet("wrap_ldi");
        tick;
        chk("wrap_after_pc", 32'(pc), 32'h1);
        chk("wrap_r0", 32'(r0), 32'h0C);

        // JGF with gf_q set, then cleared
`ifdef AU_SEQ_JGF_EN
        exp_pc = 4'd10;
`else
        exp_pc = 4'd6;
`endif
        for (int g = 0; g < 2; g++) begin
            do_reset;
            clear_rom;
            rom[0] = 8'h14; rom[1] = (g == 0) ? 8'h01 : 8'hFF;
            rom[2] = 8'h18; rom[3] = (g == 0) ? 8'hFF : 8'h01;
            rom[4] = 8'h96; rom[5] = 8'h2A;
            pulse_start;
            repeat (7) tick;
            chk_quiet($sformatf("jgf%0d_exec", g));
            tick;
            chk($sformatf("jgf%0d_pc", g), 32'(pc), (g == 0) ? 32'(exp_pc) : 32'h6);
        end

        // Random programs against the instruction-level model
        for (int r = 0; r < 8; r++) run_random(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
